// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target for the MEM-stage load/store port.
// Revision 1.0 - initial release.
`default_nettype none

module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        word_we,
  input  logic        byte_we,
  input  logic        mem_read,
  input  logic        byte_load,
  output logic        resp_valid,
  output logic [31:0] data_out,
  output logic        stall,
  output logic        misaligned
);

  localparam int         WORDS    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_WSTORE = 2'd1,
    OP_BSTORE = 2'd2,
    OP_LOAD   = 2'd3
  } op_t;

  state_t                state, state_next;
  logic [3:0]            cnt, cnt_next;
  logic                  accept;

  logic [ADDR_WIDTH+1:0] cap_addr;
  logic [31:0]           cap_data;
  op_t                   cap_op;
  logic                  cap_byte_load;
  logic                  cap_mis;

  op_t                   live_op;
  logic                  live_mis;

  logic [ADDR_WIDTH+1:0] sel_addr;
  op_t                   sel_op;
  logic                  sel_byte_load;
  logic                  sel_mis;

  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  wr_en;
  logic [31:0]           wr_word;
  logic [31:0]           rd_word;
  logic [31:0]           resp_data;

  logic [31:0]           mem [WORDS];
  logic [31:0]           data_q;
  logic                  mis_q;

  logic                  unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

  assign accept     = req_valid && (state == S_IDLE || state == S_RESP);
  assign req_ready  = (state != S_BUSY);
  assign resp_valid = (state == S_RESP);
  assign stall      = (req_valid && !resp_valid) || (state == S_BUSY);
  assign misaligned = resp_valid && mis_q;
  assign data_out   = data_q;

  // Request decode, highest priority first.
  always_comb begin
    live_op = OP_NONE;
    if (word_we)       live_op = OP_WSTORE;
    else if (byte_we)  live_op = OP_BSTORE;
    else if (mem_read) live_op = OP_LOAD;
    live_mis = ((live_op == OP_WSTORE) || (live_op == OP_LOAD && !byte_load))
               && (addr[1:0] != 2'b00);
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: if (req_valid) state_next = (LATENCY == 1) ? S_RESP : S_BUSY;
      S_BUSY: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) state_next = S_RESP;
      end
      S_RESP: begin
        if (req_valid) state_next = (LATENCY == 1) ? S_RESP : S_BUSY;
        else           state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (accept) cnt_next = CNT_INIT;
  end

  // The response word is fetched on the edge that enters RESP: from the captured
  // request when leaving BUSY, or straight from the inputs when LATENCY is 1.
  always_comb begin
    if (state == S_BUSY) begin
      sel_addr      = cap_addr;
      sel_op        = cap_op;
      sel_byte_load = cap_byte_load;
      sel_mis       = cap_mis;
    end else begin
      sel_addr      = addr[ADDR_WIDTH+1:0];
      sel_op        = live_op;
      sel_byte_load = byte_load;
      sel_mis       = live_mis;
    end
  end

  assign wr_idx = cap_addr[ADDR_WIDTH+1:2];
  assign rd_idx = sel_addr[ADDR_WIDTH+1:2];
  assign wr_en  = (state == S_RESP) && !cap_mis &&
                  (cap_op == OP_WSTORE || cap_op == OP_BSTORE);

  always_comb begin
    wr_word = mem[wr_idx];
    if (cap_op == OP_WSTORE) wr_word = cap_data;
    else                     wr_word[{cap_addr[1:0], 3'b000} +: 8] = cap_data[7:0];
  end

  // Forward a store committing on this same edge so back-to-back RAW sees new data.
  always_comb begin
    rd_word = mem[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) rd_word = wr_word;
  end

  always_comb begin
    resp_data = 32'd0;
    if (sel_op == OP_LOAD && !sel_mis) begin
      if (sel_byte_load) resp_data = {24'd0, rd_word[{sel_addr[1:0], 3'b000} +: 8]};
      else               resp_data = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      cap_addr      <= '0;
      cap_data      <= 32'd0;
      cap_op        <= OP_NONE;
      cap_byte_load <= 1'b0;
      cap_mis       <= 1'b0;
      data_q        <= 32'd0;
      mis_q         <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        cap_addr      <= addr[ADDR_WIDTH+1:0];
        cap_data      <= data_in;
        cap_op        <= live_op;
        cap_byte_load <= byte_load;
        cap_mis       <= live_mis;
      end
      if (state_next == S_RESP) begin
        data_q <= resp_data;
        mis_q  <= sel_mis;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= 32'd0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_word;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (ADDR_WIDTH=10, LATENCY=3).
`default_nettype none

module tb_dmem_responder;

  localparam int LAT = 3;

  localparam logic [3:0] T_WS    = 4'b1000;
  localparam logic [3:0] T_BS    = 4'b0100;
  localparam logic [3:0] T_LW    = 4'b0010;
  localparam logic [3:0] T_LB    = 4'b0011;
  localparam logic [3:0] T_NOP   = 4'b0000;
  localparam logic [3:0] T_WS_RD = 4'b1010;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        word_we;
  logic        byte_we;
  logic        mem_read;
  logic        byte_load;
  logic        resp_valid;
  logic [31:0] data_out;
  logic        stall;
  logic        misaligned;

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
    logic        chk;
    logic [7:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .data_in(data_in), .word_we(word_we), .byte_we(byte_we),
    .mem_read(mem_read), .byte_load(byte_load), .resp_valid(resp_valid),
    .data_out(data_out), .stall(stall), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Scoreboard: every response pops the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: resp_valid=1 with no outstanding request");
      end else begin
        e = sb.pop_front();
        if (misaligned !== e.mis) begin
          errors++;
          $display("FAIL resp%0d_misaligned: got %b expected %b", e.tag, misaligned, e.mis);
        end
        if (e.chk) begin
          checks++;
          if (data_out !== e.data) begin
            errors++;
            $display("FAIL resp%0d_data: got %h expected %h", e.tag, data_out, e.data);
          end
        end
      end
    end
  end

  task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ty,
                           input logic [31:0] ed, input logic em, input logic chk,
                           input logic [7:0] tag);
    addr      = a;
    data_in   = d;
    {word_we, byte_we, mem_read, byte_load} = ty;
    req_valid = 1'b1;
    sb.push_back('{data: ed, mis: em, chk: chk, tag: tag});
  endtask

  task automatic release_req();
    req_valid = 1'b0;
    {word_we, byte_we, mem_read, byte_load} = 4'b0000;
    addr      = 32'd0;
    data_in   = 32'd0;
  endtask

  // Waits for the response; counts cycles and BUSY/RESP handshake violations.
  task automatic wait_resp(output int k, output int bad);
    bit got;
    k = 0; bad = 0; got = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (resp_valid === 1'b1) begin
        got = 1;
        if (stall !== 1'b0) bad++;
      end else if (stall !== 1'b1 || req_ready !== 1'b0) begin
        bad++;
      end
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ty,
                      input logic [31:0] ed, input logic em, input logic chk,
                      input logic [7:0] tag, output int k, output int bad);
    int b0;
    b0 = 0;
    @(negedge clk);
    drive_req(a, d, ty, ed, em, chk, tag);
    #1;
    if (stall !== 1'b1 || req_ready !== 1'b1) b0 = 1;
    wait_resp(k, bad);
    bad += b0;
    release_req();
  endtask

  task automatic test_reset();
    int k, bad;
    reset = 1'b1;
    release_req();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || stall !== 1'b0 ||
        misaligned !== 1'b0 || data_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b resp=%b stall=%b mis=%b data=%h expected 1 0 0 0 0",
               req_ready, resp_valid, stall, misaligned, data_out);
    end
    xfer(32'h10, 32'h0, T_LW, 32'h0, 1'b0, 1'b1, 8'd1, k, bad);
  endtask

  task automatic test_word_store();
    int k, bad;
    xfer(32'h10, 32'hDEADBEEF, T_WS, 32'h0, 1'b0, 1'b0, 8'd2, k, bad);
    checks++;
    if (k != LAT || bad != 0) begin
      errors++;
      $display("FAIL store_timing: latency=%0d violations=%0d expected latency=%0d violations=0", k, bad, LAT);
    end
    xfer(32'h10, 32'h0, T_LW, 32'hDEADBEEF, 1'b0, 1'b1, 8'd3, k, bad);
    checks++;
    if (k != LAT || bad != 0) begin
      errors++;
      $display("FAIL load_timing: latency=%0d violations=%0d expected latency=%0d violations=0", k, bad, LAT);
    end
  endtask

  task automatic test_byte_lanes();
    int k, bad;
    xfer(32'h10, 32'h11223344, T_WS, 32'h0, 1'b0, 1'b0, 8'd10, k, bad);
    xfer(32'h13, 32'hFFFFFFAB, T_BS, 32'h0, 1'b0, 1'b0, 8'd11, k, bad);
    xfer(32'h10, 32'h0, T_LW, 32'hAB223344, 1'b0, 1'b1, 8'd12, k, bad);
    xfer(32'h12, 32'h0, T_LB, 32'h00000022, 1'b0, 1'b1, 8'd13, k, bad);
    xfer(32'h13, 32'h0, T_LB, 32'h000000AB, 1'b0, 1'b1, 8'd14, k, bad);
    xfer(32'h10, 32'h0, T_LB, 32'h00000044, 1'b0, 1'b1, 8'd15, k, bad);
  endtask

  task automatic test_misaligned();
    int k, bad;
    xfer(32'h04, 32'hCAFEF00D, T_WS, 32'h0, 1'b0, 1'b0, 8'd20, k, bad);
    xfer(32'h06, 32'h0, T_LW, 32'h0, 1'b1, 1'b1, 8'd21, k, bad);
    xfer(32'h05, 32'h12345678, T_WS, 32'h0, 1'b1, 1'b1, 8'd22, k, bad);
    xfer(32'h04, 32'h0, T_LW, 32'hCAFEF00D, 1'b0, 1'b1, 8'd23, k, bad);
    @(negedge clk);
    checks++;
    if (misaligned !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_pulse: got %b after response, expected 0", misaligned);
    end
  endtask

  task automatic test_wrap_priority();
    int k, bad;
    xfer(32'h1000, 32'h00001234, T_WS, 32'h0, 1'b0, 1'b0, 8'd30, k, bad);
    xfer(32'h0, 32'h0, T_LW, 32'h00001234, 1'b0, 1'b1, 8'd31, k, bad);
    xfer(32'h08, 32'h00000077, T_WS_RD, 32'h0, 1'b0, 1'b0, 8'd32, k, bad);
    xfer(32'h08, 32'h0, T_LW, 32'h00000077, 1'b0, 1'b1, 8'd33, k, bad);
    xfer(32'h08, 32'hFFFFFFFF, T_NOP, 32'h0, 1'b0, 1'b1, 8'd34, k, bad);
    xfer(32'h08, 32'h0, T_LW, 32'h00000077, 1'b0, 1'b1, 8'd35, k, bad);
  endtask

  task automatic test_back_to_back();
    int k1, b1, k2, b2;
    @(negedge clk);
    drive_req(32'h30, 32'h0BADF00D, T_WS, 32'h0, 1'b0, 1'b0, 8'd40);
    wait_resp(k1, b1);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_resp: got %b in RESP, expected 1", req_ready);
    end
    drive_req(32'h30, 32'h0, T_LW, 32'h0BADF00D, 1'b0, 1'b1, 8'd41);
    wait_resp(k2, b2);
    release_req();
    checks++;
    if (k1 != LAT || k2 != LAT || b1 != 0 || b2 != 0) begin
      errors++;
      $display("FAIL b2b_timing: gaps %0d,%0d violations %0d,%0d expected %0d,%0d and 0,0",
               k1, k2, b1, b2, LAT, LAT);
    end
  endtask

  task automatic test_reset_mid();
    int k, bad;
    @(negedge clk);
    addr = 32'h20; data_in = 32'h55;
    {word_we, byte_we, mem_read, byte_load} = T_WS;
    req_valid = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    release_req();
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || stall !== 1'b0 || req_ready !== 1'b1 || data_out !== 32'd0) begin
      errors++;
      $display("FAIL midreset_state: resp=%b stall=%b ready=%b data=%h expected 0 0 1 0",
               resp_valid, stall, req_ready, data_out);
    end
    xfer(32'h20, 32'h0, T_LW, 32'h0, 1'b0, 1'b1, 8'd50, k, bad);
    xfer(32'h30, 32'h0, T_LW, 32'h0, 1'b0, 1'b1, 8'd51, k, bad);
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_lanes();
    test_misaligned();
    test_wrap_priority();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
